// File: rtl/spi_cmd_rx.sv
// SPI slave command receiver: LSB-first 32-bit frames into {code, addr, data} with valid/ready,
// plus one-shot MISO read-back. Optional macro SPI_DUMMY_FILTER_EN drops code-0 frames silently.
`timescale 1ns/1ps
module spi_cmd_rx #(
    parameter int LEN_SPI      = 32,
    parameter int SPI_CODE_LEN = 6,
    parameter int SPI_ADDR_LEN = 10,
    parameter int SPI_DATA_LEN = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk_50M,
    input  logic                    rst_n,
    input  logic                    sck,
    input  logic                    cs_n,
    input  logic                    mosi,
    output logic                    miso,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [SPI_CODE_LEN-1:0] cmd_code,
    output logic [SPI_ADDR_LEN-1:0] cmd_addr,
    output logic [SPI_DATA_LEN-1:0] cmd_data,
    input  logic [LEN_SPI-1:0]      rd_data,
    input  logic                    rd_load,
    output logic                    frame_err,
    output logic                    cmd_ovf
);

    localparam int CNT_W = $clog2(LEN_SPI + 2);
    localparam int FL_W  = $clog2(SYNC_STAGES + 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    logic [SYNC_STAGES-1:0]  r_sck_sync, r_cs_sync, r_mosi_sync;
    logic                    r_sck_d, r_cs_d;
    logic [FL_W-1:0]         r_flush_cnt;
    logic                    r_armed;
    state_t                  r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [LEN_SPI-1:0]      r_rx_shift, r_tx_shift, r_tx_hold;
    logic                    r_tx_pend;
    logic                    r_miso;
    logic                    r_cmd_valid, r_frame_err, r_cmd_ovf;
    logic [SPI_CODE_LEN-1:0] r_cmd_code;
    logic [SPI_ADDR_LEN-1:0] r_cmd_addr;
    logic [SPI_DATA_LEN-1:0] r_cmd_data;

    logic                    w_sck, w_cs, w_mosi;
    logic                    w_sck_rise, w_cs_fall, w_cs_rise;
    logic                    w_start, w_bit, w_good, w_err;
    logic                    w_dummy, w_deliver;
    logic [LEN_SPI-1:0]      w_tx_load;

    // Synchronizers reset to idle bus levels so reset release produces no edge
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= '1;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b1;
            r_cs_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_cs_fall  = ~w_cs & r_cs_d;
    assign w_cs_rise  = w_cs & ~r_cs_d;

    // A frame may only start once cs_n has been seen high through a flushed chain;
    // this ignores the tail of a frame that was in flight when reset released.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
            r_armed     <= 1'b0;
        end else begin
            if (r_flush_cnt != FL_W'(SYNC_STAGES))
                r_flush_cnt <= r_flush_cnt + 1'b1;
            if (r_flush_cnt == FL_W'(SYNC_STAGES) && w_cs && r_cs_d)
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_bit       = 1'b0;
        w_good      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall && r_armed) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                    if (r_bit_cnt == CNT_W'(LEN_SPI)) w_good = 1'b1;
                    else                              w_err  = 1'b1;
                end else if (w_sck_rise) begin
                    w_bit = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A same-cycle rd_load wins over the held word
    assign w_tx_load = rd_load   ? rd_data :
                       r_tx_pend ? r_tx_hold : '0;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_miso     <= 1'b0;
        end else if (w_start) begin
            r_bit_cnt  <= '0;
            r_tx_shift <= w_tx_load;
            r_miso     <= w_tx_load[0];
        end else if (w_bit) begin
            r_rx_shift <= {w_mosi, r_rx_shift[LEN_SPI-1:1]};
            if (r_bit_cnt != CNT_W'(LEN_SPI + 1))
                r_bit_cnt <= r_bit_cnt + 1'b1;
            r_tx_shift <= {1'b0, r_tx_shift[LEN_SPI-1:1]};
            r_miso     <= r_tx_shift[1];
        end else if (w_good || w_err) begin
            r_miso     <= 1'b0;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_hold <= '0;
            r_tx_pend <= 1'b0;
        end else begin
            if (rd_load)
                r_tx_hold <= rd_data;
            if (w_start)
                r_tx_pend <= 1'b0;
            else if (rd_load)
                r_tx_pend <= 1'b1;
        end
    end

`ifdef SPI_DUMMY_FILTER_EN
    assign w_dummy = (r_rx_shift[LEN_SPI-1 -: SPI_CODE_LEN] == '0);
`else
    assign w_dummy = 1'b0;
`endif
    assign w_deliver = w_good && !w_dummy;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= '0;
            r_cmd_addr  <= '0;
            r_cmd_data  <= '0;
            r_frame_err <= 1'b0;
            r_cmd_ovf   <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            r_cmd_ovf   <= w_deliver && r_cmd_valid && !cmd_ready;
            if (w_deliver && (!r_cmd_valid || cmd_ready)) begin
                r_cmd_valid <= 1'b1;
                r_cmd_code  <= r_rx_shift[LEN_SPI-1 -: SPI_CODE_LEN];
                r_cmd_addr  <= r_rx_shift[SPI_DATA_LEN +: SPI_ADDR_LEN];
                r_cmd_data  <= r_rx_shift[0 +: SPI_DATA_LEN];
            end else if (r_cmd_valid && cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    assign miso      = r_miso;
    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign cmd_addr  = r_cmd_addr;
    assign cmd_data  = r_cmd_data;
    assign frame_err = r_frame_err;
    assign cmd_ovf   = r_cmd_ovf;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Directed bench for spi_cmd_rx: expected commands go into a queue when a frame is sent and are
// popped and compared when the receiver presents them.
`timescale 1ns/1ps
module tb_spi_cmd_rx;

    localparam int SYNC = 2;

    logic        clk_50M = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b1;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        rd_load = 1'b0;
    logic [31:0] rd_data = '0;
    logic        miso, cmd_valid, frame_err, cmd_ovf;
    logic [5:0]  cmd_code;
    logic [9:0]  cmd_addr;
    logic [15:0] cmd_data;

    spi_cmd_rx #(.SYNC_STAGES(SYNC)) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rd_data(rd_data), .rd_load(rd_load), .frame_err(frame_err), .cmd_ovf(cmd_ovf)
    );

    always #10 clk_50M = ~clk_50M;

    int          vectors = 0;
    int          miscompares = 0;
    int          err_pulses = 0;
    int          ovf_pulses = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: a new command is presented when valid rises or is reloaded on an accept
    logic prev_valid = 1'b0;
    int   err_run = 0;
    int   ovf_run = 0;
    always begin
        logic [31:0] w;
        @(posedge clk_50M);
        #5;
        if (cmd_valid && (!prev_valid || cmd_ready)) begin
            check("cmd_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("cmd_code", 32'(cmd_code), 32'(w[31:26]));
                check("cmd_addr", 32'(cmd_addr), 32'(w[25:16]));
                check("cmd_data", 32'(cmd_data), 32'(w[15:0]));
            end
        end
        if (frame_err) err_run++;
        else if (err_run != 0) begin
            check("frame_err_width", 32'(err_run), 32'd1);
            err_pulses++;
            err_run = 0;
        end
        if (cmd_ovf) ovf_run++;
        else if (ovf_run != 0) begin
            check("cmd_ovf_width", 32'(ovf_run), 32'd1);
            ovf_pulses++;
            ovf_run = 0;
        end
        prev_valid = cmd_valid;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: still running at %0t ns, limit 3000000 ns", $time);
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    // Mode 3 host: mosi driven on sck fall, miso sampled at sck fall
    task automatic spi_frame(input logic [31:0] w, input int nbits, input int rst_bit,
                             output logic [31:0] cap);
        cap = '0;
        @(negedge clk_50M);
        cs_n = 1'b0;
        #500;
        for (int i = 0; i < nbits; i++) begin
            if (i < 32) cap[i] = miso;
            sck  = 1'b0;
            mosi = (i < 32) ? w[i] : 1'b0;
            if (i == rst_bit) begin
                #100 rst_n = 1'b0;
                #100 rst_n = 1'b1;
                #300;
            end else begin
                #500;
            end
            sck = 1'b1;
            #500;
        end
        cs_n = 1'b1;
    endtask

    initial begin
        logic [31:0] cap;
        int          lat, e0, o0;
        logic        got;

        idle(3);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_cmd_ovf", 32'(cmd_ovf), 32'd0);
        check("rst_cmd_fields", {cmd_code, cmd_addr, cmd_data}, 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Basic decode and latency
        cmd_ready = 1'b1;
        exp_q.push_back(32'h1009_003A);
        spi_frame(32'h1009_003A, 32, -1, cap);
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk_50M);
            #5;
            lat++;
            if (cmd_valid) got = 1'b1;
        end
        check("t1_valid_seen", 32'(got), 32'd1);
        check("t1_latency_within", 32'(lat <= SYNC + 2), 32'd1);
        idle(20);
        check("t1_delivered", 32'(exp_q.size()), 32'd0);
        check("t1_no_err", 32'(err_pulses), 32'd0);
        check("t1_valid_low", 32'(cmd_valid), 32'd0);

        // Read-back then one-shot clear
        @(negedge clk_50M);
        rd_data = 32'hA5A5_1234;
        rd_load = 1'b1;
        @(negedge clk_50M);
        rd_load = 1'b0;
        rd_data = '0;
`ifndef SPI_DUMMY_FILTER_EN
        exp_q.push_back(32'h0);
`endif
        spi_frame(32'h0, 32, -1, cap);
        check("t2_miso_readback", cap, 32'hA5A5_1234);
        idle(20);
`ifndef SPI_DUMMY_FILTER_EN
        exp_q.push_back(32'h0);
`endif
        spi_frame(32'h0, 32, -1, cap);
        check("t2_miso_second", cap, 32'h0);
        idle(20);
        check("t2_delivered", 32'(exp_q.size()), 32'd0);
        check("t2_no_ovf", 32'(ovf_pulses), 32'd0);

        // Short frame, then good frame
        e0 = err_pulses;
        spi_frame(32'hFFFF_FFFF, 20, -1, cap);
        idle(20);
        check("t3_short_err", 32'(err_pulses), 32'(e0 + 1));
        exp_q.push_back(32'h2004_0000);
        spi_frame(32'h2004_0000, 32, -1, cap);
        idle(20);
        check("t3_delivered", 32'(exp_q.size()), 32'd0);
        check("t3_no_extra_err", 32'(err_pulses), 32'(e0 + 1));

        // Long frame
        spi_frame(32'h1009_003A, 33, -1, cap);
        idle(20);
        check("t4_long_err", 32'(err_pulses), 32'(e0 + 2));
        check("t4_no_cmd", 32'(cmd_valid), 32'd0);

        // Overflow while stalled
        @(negedge clk_50M);
        cmd_ready = 1'b0;
        o0 = ovf_pulses;
        exp_q.push_back(32'h4C00_0000);
        spi_frame(32'h4C00_0000, 32, -1, cap);
        idle(20);
        spi_frame(32'h3000_0000, 32, -1, cap);
        idle(20);
        check("t5_valid_held", 32'(cmd_valid), 32'd1);
        check("t5_code_held", 32'(cmd_code), 32'd19);
        check("t5_ovf_once", 32'(ovf_pulses), 32'(o0 + 1));
        check("t5_delivered", 32'(exp_q.size()), 32'd0);
        @(negedge clk_50M);
        cmd_ready = 1'b1;
        @(posedge clk_50M);
        #5;
        check("t5_valid_cleared", 32'(cmd_valid), 32'd0);

        // Reset mid-frame, released with cs_n low
        e0 = err_pulses;
        o0 = ovf_pulses;
        spi_frame(32'h1234_5678, 32, 16, cap);
        idle(20);
        check("t6_no_err", 32'(err_pulses), 32'(e0));
        check("t6_no_ovf", 32'(ovf_pulses), 32'(o0));
        check("t6_no_cmd", 32'(cmd_valid), 32'd0);
        exp_q.push_back(32'h5400_0000);
        spi_frame(32'h5400_0000, 32, -1, cap);
        idle(20);
        check("t6_delivered", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_cmd_rx.md
Name: spi_cmd_rx

Overview:
- SPI slave front end in the clk_50M domain that receives the 32-bit host command frames and converts them into parallel command strobes for the command/FSM decoder downstream.
- Deserializes MOSI LSB-first into {code, addr, data}, validates the frame length, and presents the command with a valid/ready handshake.
- Serializes the decoder's read-back word onto MISO during the next frame, which is why the host follows each read with a dummy frame.

Parameters:
- LEN_SPI, 32, frame length in bits; must equal SPI_CODE_LEN+SPI_ADDR_LEN+SPI_DATA_LEN.
- SPI_CODE_LEN, 6, command code width, frame bits [31:26].
- SPI_ADDR_LEN, 10, address width, frame bits [25:16].
- SPI_DATA_LEN, 16, data width, frame bits [15:0].
- SYNC_STAGES, 2, synchronizer depth for sck/cs_n/mosi, minimum 2.

Ports:
- clk_50M  input  1  system clock, 50 MHz.
- rst_n  input  1  reset; asynchronous, active-low.
- sck  input  1  SPI clock from host; idles high.
- cs_n  input  1  SPI chip select, active-low.
- mosi  input  1  host data, LSB first.
- miso  output  1  read-back data to host.
- cmd_valid  output  1  command available.
- cmd_ready  input  1  decoder accepts the command.
- cmd_code  output  SPI_CODE_LEN  command code.
- cmd_addr  output  SPI_ADDR_LEN  {block[7:0], ch[1:0]}.
- cmd_data  output  SPI_DATA_LEN  payload.
- rd_data  input  LEN_SPI  read-back word.
- rd_load  input  1  one-cycle strobe that latches rd_data.
- frame_err  output  1  one-cycle pulse when a frame is not exactly LEN_SPI bits.
- cmd_ovf  output  1  one-cycle pulse when a frame is dropped because a command is still pending.

Behaviour:
- Reset values:
  - All outputs are 0.
  - Synchronizer flops reset to the idle levels sck=1, cs_n=1, mosi=0, so no false edge is seen at reset release.
  - FSM resets to IDLE, bit_cnt=0, tx holding register=0, tx_pend=0.
- Synchronization and edge detection:
  - sck, cs_n and mosi pass through SYNC_STAGES flops.
  - Edges (cs_fall, cs_rise, sck_rise) are detected between the last synchronizer flop and one further flop.
- FSM state IDLE:
  - Stays in IDLE while cs_n is low with no cs_fall. This covers reset released mid-frame: that frame is ignored entirely.
  - On cs_fall: go to SHIFT, set bit_cnt=0, and load tx_shift with the hold register if tx_pend=1, otherwise with 0.
  - Clear tx_pend on that load; read-back is one-shot, so a stale word is never resent.
  - Drive miso with bit 0 of the loaded value.
- FSM state SHIFT, on each sck_rise:
  - rx_shift is shifted right and the synchronized mosi enters the MSB, so the first bit received ends up at bit 0.
  - bit_cnt increments and saturates at LEN_SPI+1.
  - tx_shift shifts right and miso takes the next bit.
  - miso therefore changes right after the host's rising edge and is stable at the host's falling-edge sample point (500 ns half-period versus roughly 80 ns of sync delay).
- FSM state SHIFT, on cs_rise:
  - If bit_cnt==LEN_SPI, the frame is good.
  - Otherwise pulse frame_err for one cycle and discard the frame; this covers short frames, over-long frames and cs_rise with no sck.
  - In both cases return to IDLE and force miso to 0.
- Good frame handling:
  - If cmd_valid=0: register cmd_code/addr/data from rx_shift and set cmd_valid on the next clk edge. Latency from pin cs_n rise to cmd_valid is SYNC_STAGES+2 clk cycles.
  - If cmd_valid=1 and cmd_ready=0 in the same cycle: drop the new frame, pulse cmd_ovf, and keep the pending command unchanged.
  - If cmd_valid=1 and cmd_ready=1 in the same cycle: accept the old command and load the new one, so cmd_valid stays 1.
- Handshake: cmd_valid clears on the cycle after cmd_valid&&cmd_ready. cmd_* are stable while cmd_valid=1.
- Read-back hold register:
  - rd_load sets hold=rd_data and tx_pend=1 at any time.
  - A rd_load during SHIFT does not alter the frame in flight; it applies to the next frame.
  - If rd_load and cs_fall occur in the same cycle, the new rd_data is sent in that frame and tx_pend ends at 0.
- cs_fall while in SHIFT cannot occur, because it requires a preceding cs_rise.
- rst_n assertion mid-frame clears everything immediately; no cmd_valid or frame_err is produced for the aborted frame.

Optional Feature:
- Macro SPI_DUMMY_FILTER_EN.
- Defined: a good frame with cmd_code==0 (dummy frame) is consumed silently, with no cmd_valid and no cmd_ovf; MISO read-back still occurs normally.
- Undefined: code 0 frames are delivered like any other command.

Test Plan:
- Frame 0x1009003A, i.e. {6'd4, {8'd2,2'd1}, 16'h003A}, with cmd_ready=1 -> single cmd_valid, cmd_code=4, cmd_addr=0x009, cmd_data=0x003A, cmd_valid within SYNC_STAGES+2 cycles of cs_n rise, no frame_err.
- rd_load with rd_data=0xA5A5_1234, then frame {6'd0,0,0} -> host captures 0xA5A51234 LSB-first. A second dummy frame returns 0x00000000. With SPI_DUMMY_FILTER_EN defined there is no cmd_valid; undefined gives cmd_valid with code 0.
- Frame truncated after 20 sck edges, then cs_n high -> frame_err pulses for exactly 1 cycle with no cmd_valid. A following good 32-bit frame {6'd8,10'd4,0} decodes to code 8, addr 4.
- Frame with 33 sck edges -> frame_err pulses, no cmd_valid.
- cmd_ready held 0, two good frames sent (codes 19 then 12) -> cmd_valid stays 1 with code 19 and cmd_ovf pulses once. Raising cmd_ready clears cmd_valid one cycle later.
- rst_n asserted for 100 ns at bit 16 of a frame, then released while cs_n is still low -> no output activity for that frame. The next complete frame {6'd21,0,0} decodes as code 21.
